// File: rtl/game_state_controller.sv
// game_state_controller: match sequencer driving the 2-bit game state code
// (00 off, 01 preparation, 10 attack) and tracking ships placed, shots and hits.
//
// Ports:
//   i_clk               system clock, rising edge
//   i_reset             synchronous active-high reset
//   i_start_btn         start/restart button level (debounced, synchronous)
//   i_confirm_btn       confirm button level (debounced, synchronous)
//   i_place_ok          one-cycle pulse: a ship was placed legally
//   i_fire_btn          fire button level (debounced, synchronous)
//   i_shot_hit          hit flag for the target cell, sampled with the fire edge
//   o_game_state_code   00 off/end, 01 preparation, 10 attack (never 11)
//   o_ships_placed      ships placed so far
//   o_shots_left        remaining shots
//   o_hits              hits scored
//   o_game_over         high while in END
//   o_win               high in END when the hit target was reached
module game_state_controller #(
    parameter int NUM_SHIPS   = 3,
    parameter int TARGET_HITS = 9,
    parameter int MAX_SHOTS   = 20
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start_btn,
    input  logic       i_confirm_btn,
    input  logic       i_place_ok,
    input  logic       i_fire_btn,
    input  logic       i_shot_hit,
    output logic [1:0] o_game_state_code,
    output logic [3:0] o_ships_placed,
    output logic [4:0] o_shots_left,
    output logic [4:0] o_hits,
    output logic       o_game_over,
    output logic       o_win
);
    localparam logic [3:0] LP_SHIPS  = 4'(NUM_SHIPS);
    localparam logic [4:0] LP_TARGET = 5'(TARGET_HITS);
    localparam logic [4:0] LP_MAX    = 5'(MAX_SHOTS);

    typedef enum logic [1:0] {S_OFF, S_PREP, S_ATTACK, S_END} state_t;

    state_t     r_state;
    logic [1:0] r_code;
    logic [3:0] r_ships;
    logic [4:0] r_shots;
    logic [4:0] r_hits;
    logic       r_game_over;
    logic       r_win;
    logic       r_start_q;
    logic       r_confirm_q;
    logic       r_fire_q;

    logic       w_start_edge;
    logic       w_confirm_edge;
    logic       w_fire_edge;
    logic [3:0] w_ships_next;
    logic [4:0] w_shots_next;
    logic [4:0] w_hits_next;

    assign w_start_edge   = i_start_btn & ~r_start_q;
    assign w_confirm_edge = i_confirm_btn & ~r_confirm_q;
    assign w_fire_edge    = i_fire_btn & ~r_fire_q;
    // Placement increment is folded in before the confirm check so a
    // coincident final placement and confirm still starts the attack.
    assign w_ships_next   = (i_place_ok && r_ships < LP_SHIPS) ? r_ships + 4'd1 : r_ships;
    // Shots never reach below zero here: hitting zero always ends the game.
    assign w_shots_next   = r_shots - 5'd1;
    assign w_hits_next    = r_hits + {4'd0, i_shot_hit};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_OFF;
            r_code      <= 2'b00;
            r_ships     <= '0;
            r_shots     <= LP_MAX;
            r_hits      <= '0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_start_q   <= 1'b0;
            r_confirm_q <= 1'b0;
            r_fire_q    <= 1'b0;
        end else begin
            r_start_q   <= i_start_btn;
            r_confirm_q <= i_confirm_btn;
            r_fire_q    <= i_fire_btn;
            case (r_state)
                S_OFF: if (w_start_edge) begin
                    r_state <= S_PREP;
                    r_code  <= 2'b01;
                    r_ships <= '0;
                    r_hits  <= '0;
                    r_win   <= 1'b0;
                    r_shots <= LP_MAX;
                end
                S_PREP: begin
                    r_ships <= w_ships_next;
                    if (w_confirm_edge && w_ships_next == LP_SHIPS) begin
                        r_state <= S_ATTACK;
                        r_code  <= 2'b10;
                    end
                end
                S_ATTACK: if (w_fire_edge) begin
                    r_shots <= w_shots_next;
                    r_hits  <= w_hits_next;
                    // Win is checked first so a winning last shot counts as a win.
                    if (w_hits_next == LP_TARGET || w_shots_next == 5'd0) begin
                        r_state     <= S_END;
                        r_code      <= 2'b00;
                        r_game_over <= 1'b1;
                        r_win       <= (w_hits_next == LP_TARGET);
                    end
                end
                S_END: if (w_start_edge) begin
                    r_state     <= S_OFF;
                    r_code      <= 2'b00;
                    r_ships     <= '0;
                    r_shots     <= LP_MAX;
                    r_hits      <= '0;
                    r_game_over <= 1'b0;
                    r_win       <= 1'b0;
                end
                default: r_state <= S_OFF;
            endcase
        end
    end

    assign o_game_state_code = r_code;
    assign o_ships_placed    = r_ships;
    assign o_shots_left      = r_shots;
    assign o_hits            = r_hits;
    assign o_game_over       = r_game_over;
    assign o_win             = r_win;
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed scenarios for game_state_controller with
// hand-computed expectations; inputs change and outputs are sampled on the
// falling clock edge.
module tb_game_state_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       confirm_btn;
    logic       place_ok;
    logic       fire_btn;
    logic       shot_hit;
    logic [1:0] code;
    logic [3:0] ships;
    logic [4:0] shots;
    logic [4:0] hits;
    logic       game_over;
    logic       win;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    game_state_controller #(.NUM_SHIPS(3), .TARGET_HITS(9), .MAX_SHOTS(20)) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_start_btn(start_btn),
        .i_confirm_btn(confirm_btn),
        .i_place_ok(place_ok),
        .i_fire_btn(fire_btn),
        .i_shot_hit(shot_hit),
        .o_game_state_code(code),
        .o_ships_placed(ships),
        .o_shots_left(shots),
        .o_hits(hits),
        .o_game_over(game_over),
        .o_win(win)
    );

    // Advance one cycle; the state code must never read 11.
    task automatic tick();
        @(negedge clk);
        n_tests++;
        if (code === 2'b11 || $isunknown(code)) begin
            n_fail++;
            $display("FAIL code_never_11: got %b", code);
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1; tick(); start_btn = 1'b0; tick();
    endtask

    task automatic press_confirm();
        confirm_btn = 1'b1; tick(); confirm_btn = 1'b0; tick();
    endtask

    task automatic pulse_place();
        place_ok = 1'b1; tick(); place_ok = 1'b0; tick();
    endtask

    task automatic fire(input logic h);
        shot_hit = h; fire_btn = 1'b1; tick(); fire_btn = 1'b0; shot_hit = 1'b0; tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask

    task automatic enter_attack();
        do_reset();
        press_start();
        repeat (3) pulse_place();
        press_confirm();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({code, ships, shots, hits, game_over, win} !== {2'b00, 4'd0, 5'd20, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got code=%b ships=%0d shots=%0d hits=%0d go=%b win=%b, want 00/0/20/0/0/0",
                     code, ships, shots, hits, game_over, win);
        end
    endtask

    task automatic test_start_hold();
        start_btn = 1'b1;
        tick();
        n_tests++;
        if (code !== 2'b01) begin
            n_fail++;
            $display("FAIL start_to_prep: got code=%b, want 01", code);
        end
        repeat (9) tick();
        start_btn = 1'b0;
        tick();
        n_tests++;
        if ({code, ships} !== {2'b01, 4'd0}) begin
            n_fail++;
            $display("FAIL start_held: got code=%b ships=%0d, want 01/0", code, ships);
        end
        press_start();
        n_tests++;
        if ({code, ships, shots} !== {2'b01, 4'd0, 5'd20}) begin
            n_fail++;
            $display("FAIL start_in_prep: got code=%b ships=%0d shots=%0d, want 01/0/20", code, ships, shots);
        end
    endtask

    task automatic test_prep();
        pulse_place();
        pulse_place();
        press_confirm();
        n_tests++;
        if ({code, ships} !== {2'b01, 4'd2}) begin
            n_fail++;
            $display("FAIL confirm_short: got code=%b ships=%0d, want 01/2", code, ships);
        end
        place_ok = 1'b1; confirm_btn = 1'b1;
        tick();
        place_ok = 1'b0; confirm_btn = 1'b0;
        n_tests++;
        if ({code, ships} !== {2'b10, 4'd3}) begin
            n_fail++;
            $display("FAIL place_confirm_same: got code=%b ships=%0d, want 10/3", code, ships);
        end
        tick();
        pulse_place();
        press_confirm();
        press_start();
        n_tests++;
        if ({code, ships, shots, hits} !== {2'b10, 4'd3, 5'd20, 5'd0}) begin
            n_fail++;
            $display("FAIL attack_ignores: got code=%b ships=%0d shots=%0d hits=%0d, want 10/3/20/0",
                     code, ships, shots, hits);
        end
    endtask

    task automatic test_win();
        for (int i = 0; i < 8; i++) fire(1'b1);
        n_tests++;
        if ({code, shots, hits, game_over} !== {2'b10, 5'd12, 5'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL win_before_last: got code=%b shots=%0d hits=%0d go=%b, want 10/12/8/0",
                     code, shots, hits, game_over);
        end
        fire(1'b1);
        n_tests++;
        if ({code, shots, hits, game_over, win} !== {2'b00, 5'd11, 5'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL win_end: got code=%b shots=%0d hits=%0d go=%b win=%b, want 00/11/9/1/1",
                     code, shots, hits, game_over, win);
        end
        fire(1'b1);
        n_tests++;
        if ({code, shots, hits, game_over, win} !== {2'b00, 5'd11, 5'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL end_holds: got code=%b shots=%0d hits=%0d go=%b win=%b, want 00/11/9/1/1",
                     code, shots, hits, game_over, win);
        end
    endtask

    task automatic test_reset_mid_attack();
        enter_attack();
        fire(1'b1); fire(1'b0); fire(1'b1); fire(1'b0); fire(1'b0);
        n_tests++;
        if ({code, shots, hits} !== {2'b10, 5'd15, 5'd2}) begin
            n_fail++;
            $display("FAIL mid_attack: got code=%b shots=%0d hits=%0d, want 10/15/2", code, shots, hits);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({code, ships, shots, hits, game_over, win} !== {2'b00, 4'd0, 5'd20, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_attack: got code=%b ships=%0d shots=%0d hits=%0d go=%b win=%b, want 00/0/20/0/0/0",
                     code, ships, shots, hits, game_over, win);
        end
        tick();
    endtask

    task automatic test_lose();
        enter_attack();
        for (int i = 0; i < 19; i++) fire(i < 8);
        n_tests++;
        if ({code, shots, hits, game_over} !== {2'b10, 5'd1, 5'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL lose_before_last: got code=%b shots=%0d hits=%0d go=%b, want 10/1/8/0",
                     code, shots, hits, game_over);
        end
        fire(1'b0);
        n_tests++;
        if ({code, shots, hits, game_over, win} !== {2'b00, 5'd0, 5'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL lose_end: got code=%b shots=%0d hits=%0d go=%b win=%b, want 00/0/8/1/0",
                     code, shots, hits, game_over, win);
        end
        fire(1'b1);
        n_tests++;
        if ({code, shots, hits, game_over, win} !== {2'b00, 5'd0, 5'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fire_after_end: got code=%b shots=%0d hits=%0d go=%b win=%b, want 00/0/8/1/0",
                     code, shots, hits, game_over, win);
        end
    endtask

    task automatic test_last_shot_win();
        enter_attack();
        for (int i = 0; i < 20; i++) fire(i >= 11);
        n_tests++;
        if ({code, shots, hits, game_over, win} !== {2'b00, 5'd0, 5'd9, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL last_shot_win: got code=%b shots=%0d hits=%0d go=%b win=%b, want 00/0/9/1/1",
                     code, shots, hits, game_over, win);
        end
        press_start();
        n_tests++;
        if ({code, ships, shots, hits, game_over, win} !== {2'b00, 4'd0, 5'd20, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL end_to_off: got code=%b ships=%0d shots=%0d hits=%0d go=%b win=%b, want 00/0/20/0/0/0",
                     code, ships, shots, hits, game_over, win);
        end
        press_start();
        n_tests++;
        if ({code, ships, shots} !== {2'b01, 4'd0, 5'd20}) begin
            n_fail++;
            $display("FAIL restart_to_prep: got code=%b ships=%0d shots=%0d, want 01/0/20", code, ships, shots);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_btn = 1'b0;
        confirm_btn = 1'b0;
        place_ok = 1'b0;
        fire_btn = 1'b0;
        shot_hit = 1'b0;
        test_reset();
        test_start_hold();
        test_prep();
        test_win();
        test_reset_mid_attack();
        test_lose();
        test_last_shot_win();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
